// File: rtl/mul_ha_pkg.sv
// Shared constants, FSM state type and row-weight helper for the
// approximate 8x8 multiplier's half-adder array reduction stage.
package mul_ha_pkg;

  localparam int NUM_ROWS = 4;
  localparam int B_W      = 7;
  localparam int T_W      = 9;
  localparam int OUT_W    = 16;
  localparam int CNT_W    = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  // Row k sits at bit position 2k of the final product.
  function automatic int unsigned row_weight(input int unsigned k);
    return k << 1;
  endfunction

endpackage

// File: rtl/ha_row_value.sv
// Combinational weighted value of one half-adder array row:
// R_k = (t + (b << 2)) << 2k, evaluated at OUT_W+1 bits.
module ha_row_value
  import mul_ha_pkg::*;
(
  input  logic [B_W-1:0]   b,
  input  logic [T_W-1:0]   t,
  input  logic [CNT_W-1:0] k,
  output logic [OUT_W:0]   value
);

  logic [OUT_W:0] base;

  // Align b two places above t, then shift the pair to the row's weight.
  always_comb begin
    base  = {{(OUT_W + 1 - T_W){1'b0}}, t}
          + ({{(OUT_W + 1 - B_W){1'b0}}, b} << 2);
    value = base << row_weight(32'(k));
  end

endmodule

// File: rtl/ha_array_reducer.sv
// Multi-cycle final adder for the half-adder array: captures four weighted
// b/t row pairs, accumulates one row per clock, and presents the 16-bit
// product plus an overflow flag behind a valid/ready handshake.
module ha_array_reducer
  import mul_ha_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B_W-1:0]   ha_array_0_b,
  input  logic [B_W-1:0]   ha_array_1_b,
  input  logic [B_W-1:0]   ha_array_2_b,
  input  logic [B_W-1:0]   ha_array_3_b,
  input  logic [T_W-1:0]   ha_array_0_t,
  input  logic [T_W-1:0]   ha_array_1_t,
  input  logic [T_W-1:0]   ha_array_2_t,
  input  logic [T_W-1:0]   ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic             overflow,
  output logic             busy
);

  state_t state, next_state;

  logic [NUM_ROWS-1:0][B_W-1:0] b_q;
  logic [NUM_ROWS-1:0][T_W-1:0] t_q;
  logic [CNT_W-1:0]             cnt;
  logic [OUT_W:0]               acc;
  logic                         carry_q;
  logic [OUT_W:0]               row_val;
  logic [OUT_W+1:0]             sum;
  logic [OUT_W-1:0]             product_q;
  logic                         overflow_q;
  logic                         accept;
  logic                         load_result;
  logic                         last_row;

  ha_row_value u_row_value (
    .b     (b_q[cnt]),
    .t     (t_q[cnt]),
    .k     (cnt),
    .value (row_val)
  );

  // One extra bit above the accumulator catches the carry out.
  assign sum      = {1'b0, acc} + {1'b0, row_val};
  assign last_row = (cnt == CNT_W'(NUM_ROWS - 1));
  assign product  = product_q;
  assign overflow = overflow_q;

  // State register; reset returns to IDLE and abandons any operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_state  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    accept      = 1'b0;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = ACC;
        end
      end
      ACC: begin
        if (last_row) begin
          load_result = 1'b1;
          next_state  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Row capture, accumulation and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the captured row registers are cleared on reset too, so no
      // stale operands from an abandoned operation survive.
      b_q        <= '0;
      t_q        <= '0;
      cnt        <= '0;
      acc        <= '0;
      carry_q    <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        b_q     <= {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
        t_q     <= {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
        acc     <= '0;
        cnt     <= '0;
        carry_q <= 1'b0;
      end else if (state == ACC) begin
        acc     <= sum[OUT_W:0];
        carry_q <= carry_q | sum[OUT_W+1];
        cnt     <= cnt + 1'b1;
      end
      // The result registers only change on entry to DONE, so they hold
      // through backpressure and after the output handshake.
      if (load_result) begin
        product_q  <= sum[OUT_W-1:0];
        overflow_q <= sum[OUT_W] | sum[OUT_W+1] | carry_q;
      end
    end
  end

endmodule

// File: tb/tb_ha_array_reducer.sv
// Directed self-checking bench for ha_array_reducer.
module tb_ha_array_reducer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  b0, b1, b2, b3;
  logic [8:0]  t0, t1, t2, t3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  ha_array_reducer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b0),
    .ha_array_1_b (b1),
    .ha_array_2_b (b2),
    .ha_array_3_b (b3),
    .ha_array_0_t (t0),
    .ha_array_1_t (t1),
    .ha_array_2_t (t2),
    .ha_array_3_t (t3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rows(input logic [3:0][6:0] bv, input logic [3:0][8:0] tv);
    b0 = bv[0]; b1 = bv[1]; b2 = bv[2]; b3 = bv[3];
    t0 = tv[0]; t1 = tv[1]; t2 = tv[2]; t3 = tv[3];
  endtask

  // Present a row set at a negedge and return at the negedge after the accept edge.
  task automatic accept(input string tag, input logic [3:0][6:0] bv, input logic [3:0][8:0] tv);
    int guard;
    set_rows(bv, tv);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    set_rows('0, '0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0][6:0] bv, input logic [3:0][8:0] tv,
                        input logic [15:0] exp_p, input logic exp_o);
    int lat;
    accept(tag, bv, tv);
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_product"}, 32'(product), 32'(exp_p));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_o));
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_product_hold"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int lat;
    logic [3:0][6:0] bz;
    logic [3:0][8:0] tz;
    logic [3:0][6:0] bv;
    logic [3:0][8:0] tv;
    bz = '0;
    tz = '0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_rows(bz, tz);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // Row 0 t bit 0 only: weight 1.
    tv = tz; tv[0] = 9'h001;
    run_op("t0_lsb", bz, tv, 16'h0001, 1'b0);

    // Row 3 b bit 6 only: 2^(6+6+2) = 16384.
    bv = bz; bv[3] = 7'h40;
    run_op("b3_msb", bv, tz, 16'h4000, 1'b0);

    // Row 1 full: (511 + 508) << 2 = 4076.
    bv = bz; bv[1] = 7'h7F;
    tv = tz; tv[1] = 9'h1FF;
    run_op("row1_full", bv, tv, 16'd4076, 1'b0);

    // All rows full: 1019 * 85 = 86615 -> wraps to 21079 with overflow.
    bv = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    tv = {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
    run_op("all_full", bv, tv, 16'h5257, 1'b1);

    // Backpressure: inputs change and in_valid stays high while busy.
    tv = tz; tv[2] = 9'h003;                 // (3) << 4 = 48
    accept("bp", bz, tv);
    in_valid = 1'b1;
    b3 = 7'h40;                              // would give 16384 if re-captured
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_product", 32'(product), 32'd48);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("bp_no_same_cycle_accept", 32'(busy), 32'd0);
    check("bp_in_ready_next", 32'(in_ready), 32'd1);
    // in_valid still high with b3=0x40: accepted on this edge.
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    set_rows(bz, tz);
    check("bp_reaccept", 32'(busy), 32'd1);
    wait_out(lat);
    check("bp2_latency", 32'(lat), 32'd4);
    check("bp2_product", 32'(product), 32'h4000);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;

    // Reset during the second ACC cycle discards the operation.
    bv = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
    tv = {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
    accept("mid_rst", bv, tv);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_product", 32'(product), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) lat++;
    end
    check("mid_rst_no_output", 32'(lat), 32'd0);

    bv = bz; bv[1] = 7'h7F;
    tv = tz; tv[1] = 9'h1FF;
    run_op("post_rst", bv, tv, 16'd4076, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
